// File: rtl/gfx_pkg.sv
// Shared shader-group constants and the group ID type.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package gfx;
  localparam int SHADER_GROUPS     = 16;
  localparam int SHADER_GROUP_BITS = $clog2(SHADER_GROUPS);

  typedef logic [SHADER_GROUP_BITS-1:0] group_id;
endpackage

// File: rtl/gfx_shader_group_ring.sv
// Ring FIFO of group IDs with read/write pointers and an occupancy counter.
// Latency: an entry written at edge N is visible at the head from cycle N+1.
// Backpressure: none; the caller must never push when full or pop when empty.
module gfx_shader_group_ring #(
  parameter int DEPTH = 16,
  parameter int W     = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int PTR_BITS = $clog2(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE = (PTR_BITS+1)'(1);

  logic [W-1:0]        mem [DEPTH];
  logic [PTR_BITS-1:0] wr_ptr;
  logic [PTR_BITS-1:0] rd_ptr;

  assign head = mem[rd_ptr];

  // Pointer and occupancy update; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop)      count <= count + CNT_ONE;
      else if (!push && pop) count <= count - CNT_ONE;
    end
  end

  // Storage write; contents are deliberately left unreset
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/gfx_shader_group_requeue.sv
// Re-queues returning shader groups in arrival order and offers them to fetch.
// Latency: a group returned at edge N is offered from cycle N+1, no bypass.
// Backpressure: fetch side valid/ready; loop-back side has none, duplicates are dropped.
module gfx_shader_group_requeue
  import gfx::*;
#(
  parameter int  GROUPS     = SHADER_GROUPS,
  localparam int GROUP_BITS = $clog2(GROUPS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  loop_valid,
  input  logic [GROUP_BITS-1:0] loop_group,
  output logic                  fetch_valid,
  input  logic                  fetch_ready,
  output logic [GROUP_BITS-1:0] fetch_group,
  output logic [GROUP_BITS:0]   queued,
  output logic                  idle,
  output logic                  dup_err
);
  // One bit per group: set while that group sits in the ring.
  logic [GROUPS-1:0] res;
  logic              push;
  logic              pop;
  logic              dup;

  assign push        = loop_valid & ~res[loop_group];
  assign dup         = loop_valid &  res[loop_group];
  assign fetch_valid = (queued != '0);
  assign pop         = fetch_valid & fetch_ready;
  assign idle        = (queued == '0) & ~loop_valid;

  gfx_shader_group_ring #(
    .DEPTH (GROUPS),
    .W     (GROUP_BITS)
  ) u_ring (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (loop_group),
    .pop       (pop),
    .head      (fetch_group),
    .count     (queued)
  );

  // Residency tracking; a push never targets the popped group since its bit is still set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res <= '0;
    end else begin
      if (pop)  res[fetch_group] <= 1'b0;
      if (push) res[loop_group]  <= 1'b1;
    end
  end

  // Sticky flag for a dropped duplicate return
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   dup_err <= 1'b0;
    else if (dup) dup_err <= 1'b1;
  end

  a_queued_bound: assert property (@(posedge clk) disable iff (!rst_n)
    queued <= (GROUP_BITS+1)'(GROUPS));
  a_res_count: assert property (@(posedge clk) disable iff (!rst_n)
    $countones(res) == int'(queued));
  a_head_resident: assert property (@(posedge clk) disable iff (!rst_n)
    fetch_valid |-> res[fetch_group]);
endmodule

// File: doc/gfx_shader_group_requeue.md
Name: gfx_shader_group_requeue

Overview:
- Front-end consumer of the back-end loop-back stream (`loop_valid`/`loop_group`). The back-end writeback stage asserts this stream once per executed instruction group and once per setup submit.
- Queues the returning group IDs in FIFO order and re-offers them to front-end fetch over a valid/ready handshake.
- The producer side has no backpressure. Capacity therefore equals the number of groups, and a per-group residency bitmap detects protocol violations (duplicate returns).

Parameters:
- GROUPS, 16, number of hardware groups; must be a power of two, ≥ 2.
- GROUP_BITS, $clog2(GROUPS), width of a group ID; derived, not overridden.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- loop_valid  in  1  group returning from back end or setup submit; no ready
- loop_group  in  GROUP_BITS  ID of the returning group
- fetch_valid  out  1  a queued group is offered to fetch
- fetch_ready  in  1  fetch accepts `fetch_group` this cycle
- fetch_group  out  GROUP_BITS  head-of-queue group ID
- queued  out  GROUP_BITS+1  number of groups currently queued
- idle  out  1  queue empty and no push in progress
- dup_err  out  1  sticky: a duplicate group return was dropped

Behaviour:
- Storage: ring of GROUPS entries × GROUP_BITS, write pointer `wr_ptr`, read pointer `rd_ptr`, counter `queued`, residency bitmap `res[GROUPS]`.
- Reset (async): `wr_ptr`=`rd_ptr`=0, `queued`=0, `res`=0, `dup_err`=0.
  - Outputs during and after reset: `fetch_valid`=0, `idle`=1, `dup_err`=0.
  - Ring contents are not reset; `fetch_group` is don't-care while `fetch_valid`=0.
- `fetch_valid` = (`queued` != 0). `fetch_group` = ring[`rd_ptr`], read combinationally from flops.
- pop = `fetch_valid` & `fetch_ready`. On pop:
  - `rd_ptr` += 1, wrapping modulo GROUPS.
  - `res`[`fetch_group`] cleared.
- push = `loop_valid` & ~`res`[`loop_group`], evaluated on the pre-edge bitmap. On push:
  - ring[`wr_ptr`] ← `loop_group`.
  - `wr_ptr` += 1, wrapping.
  - `res`[`loop_group`] set.
- Latency: a group pushed at edge N is offered from cycle N+1. There is no same-cycle bypass.
- `queued` next = `queued` + push − pop. Simultaneous push and pop leave `queued` unchanged.
- Duplicate: `loop_valid` & `res`[`loop_group`].
  - The entry is dropped and `dup_err` is set at the next edge; it stays set until reset.
  - This also covers the case where the returning group equals the group being popped in the same cycle: it is a duplicate, dropped, and its `res` bit ends cleared.
- Full: `queued`==GROUPS.
  - A push while full is impossible without a duplicate, because all `res` bits are set, so the incoming group is dropped as a duplicate.
  - No wr/rd pointer collision ever occurs.
- `idle` = (`queued`==0) & ~`loop_valid`.
- `fetch_ready` while `fetch_valid`=0 has no effect.
- `fetch_group` must remain stable while `fetch_valid`=1 & `fetch_ready`=0. Pushes never modify the head entry.
- Assertions:
  - `queued` ≤ GROUPS.
  - popcount(`res`) == `queued`.
  - The `res` bit of the head group is set whenever `fetch_valid`=1.

Decomposition:
- `group_id` typedef and `SHADER_GROUPS` constant live in the `gfx` package; the module binds GROUPS to `SHADER_GROUPS` at instantiation.
- One natural sub-module: `gfx_shader_group_ring` (pointer/counter/storage FIFO, no dedup).
- The top level adds the residency bitmap, duplicate filtering and `dup_err`.

Test Plan:
- Reset, then `loop_valid`=1 with group 5 for one cycle, `fetch_ready`=0 → next cycle `fetch_valid`=1, `fetch_group`=5, `queued`=1, `idle`=0; held stable for 10 cycles.
- Push 3, 7, 1 on consecutive cycles with `fetch_ready`=1 throughout → groups 3, 7, 1 are popped in that order, one per cycle starting the cycle after each push; `queued` ends at 0 and `idle`=1.
- Push all groups 0..15 with `fetch_ready`=0 → `queued`=16. Then push 9 → dropped, `dup_err`=1, `queued` stays 16. Drain → output is 0..15 in order.
- With head=4 popping, `loop_valid` with group 4 in the same cycle → dropped, `dup_err`=1, `queued` decrements by 1, `res[4]`=0.
- Steady state of one push and one pop per cycle over 40 cycles (forcing pointer wrap) → `queued` stays constant and output order equals input order.
- Assert `rst_n` mid-stream with `queued`=6 → `fetch_valid`=0 and `queued`=0 immediately (asynchronous); after release, a push of 2 yields `fetch_group`=2 one cycle later.
